// File: rtl/memory_access_stage_pkg.sv
// Shared widths and the MEM/WB bundle for the memory access stage.
package memory_access_stage_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              regwrite;
    logic              mem2reg;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] aludata;
    logic [DATA_W-1:0] memdata;
  } memwb_t;

endpackage

// File: rtl/memory_access_stage_data_memory.sv
// Word-addressed data memory (module data_memory).
// Synchronous read and write; the read returns the word held before a same-edge write.
module data_memory
  import memory_access_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_access_stage.sv
// MIPS MEM stage: data memory, MEM/WB register and write-back mux.
// Optional alignment check enabled by defining MEM_ALIGN_CHECK_EN.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              MEMMemWRITE,
  input  logic              mem2Reg1,
  input  logic              MEMRegWRITE,
  input  logic [REG_W-1:0]  Rd2,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] BusBF1,
  output logic              WBRegWRITE,
  output logic [REG_W-1:0]  RdWB,
  output logic [DATA_W-1:0] WBdata,
  output logic [DATA_W-1:0] MemDataWB,
  output logic [DATA_W-1:0] AluDataWB,
  output logic              MisalignOUT
);

  logic              misalign;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              regwrite_q;
  logic              mem2reg_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] alu_q;
  memwb_t            wb;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  assign misalign = (ALUresult[1:0] != 2'b00) && (MEMMemWRITE || mem2Reg1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)         misalign_q <= 1'b0;
    else if (misalign) misalign_q <= 1'b1;
  end

  assign MisalignOUT = misalign_q;
`else
  assign misalign    = 1'b0;
  assign MisalignOUT = 1'b0;
`endif

  // Gate with nRST so an edge during reset cannot corrupt memory.
  assign mem_we = MEMMemWRITE && nRST && !misalign;

  data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
    .clk   (CLK),
    .rst_n (nRST),
    .we    (mem_we),
    .addr  (ALUresult[ADDR_W+1:2]),
    .wdata (BusBF1),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regwrite_q <= 1'b0;
      mem2reg_q  <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
    end else begin
      regwrite_q <= MEMRegWRITE && !misalign;
      mem2reg_q  <= mem2Reg1;
      rd_q       <= Rd2;
      alu_q      <= ALUresult;
    end
  end

  assign wb = '{regwrite: regwrite_q, mem2reg: mem2reg_q, rd: rd_q,
                aludata: alu_q, memdata: mem_rdata};

  assign WBRegWRITE = wb.regwrite;
  assign RdWB       = wb.rd;
  assign AluDataWB  = wb.aludata;
  assign MemDataWB  = wb.memdata;
  assign WBdata     = wb.mem2reg ? wb.memdata : wb.aludata;

endmodule
